// File: rtl/mmul_operand_sequencer.sv
// Operand framing front end for the matrix multiplier: validates a dimension command, then tags A and B elements with row/col/last.
// Optional abort support is enabled by defining MMUL_SEQ_ABORT_EN.
module mmul_operand_sequencer #(
   parameter int DATA_W  = 16,
   parameter int DIM_W   = 4,
   parameter int MAX_DIM = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [DIM_W-1:0]  cmd_ra_i,
   input  logic [DIM_W-1:0]  cmd_ca_i,
   input  logic [DIM_W-1:0]  cmd_rb_i,
   input  logic [DIM_W-1:0]  cmd_cb_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_sel_o,
   output logic [DIM_W-1:0]  out_row_o,
   output logic [DIM_W-1:0]  out_col_o,
   output logic              out_last_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o
`ifdef MMUL_SEQ_ABORT_EN
   ,
   input  logic              abort_i,
   output logic              aborted_o
`endif
);

   localparam logic [DIM_W-1:0] MAX_V = DIM_W'(MAX_DIM);
   localparam logic [DIM_W-1:0] ONE_V = DIM_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      STREAM_A,
      STREAM_B,
      FIN,
      REJ
   } state_t;

   state_t           state_q, state_d;
   logic [DIM_W-1:0] ra_q, ra_d, ca_q, ca_d, rb_q, rb_d, cb_q, cb_d;
   logic [DIM_W-1:0] row_q, row_d, col_q, col_d;
   logic             sel_q, sel_d;
   logic [1:0]       err_code_q, err_code_d;
`ifdef MMUL_SEQ_ABORT_EN
   logic             aborted_q, aborted_d;
`endif

   logic             streaming;
   logic             xfer;
   logic [DIM_W-1:0] cur_rows, cur_cols;
   logic             row_end, col_end, last_elem;

   // The active matrix is chosen by sel: A uses RA x CA, B uses RB x CB.
   assign streaming = (state_q == STREAM_A) || (state_q == STREAM_B);
   assign xfer      = streaming && in_valid_i && out_ready_i;
   assign cur_rows  = sel_q ? rb_q : ra_q;
   assign cur_cols  = sel_q ? cb_q : ca_q;
   assign row_end   = (row_q == cur_rows - ONE_V);
   assign col_end   = (col_q == cur_cols - ONE_V);
   assign last_elem = row_end && col_end;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         ra_q       <= '0;
         ca_q       <= '0;
         rb_q       <= '0;
         cb_q       <= '0;
         row_q      <= '0;
         col_q      <= '0;
         sel_q      <= 1'b0;
         err_code_q <= 2'b00;
`ifdef MMUL_SEQ_ABORT_EN
         aborted_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ra_q       <= ra_d;
         ca_q       <= ca_d;
         rb_q       <= rb_d;
         cb_q       <= cb_d;
         row_q      <= row_d;
         col_q      <= col_d;
         sel_q      <= sel_d;
         err_code_q <= err_code_d;
`ifdef MMUL_SEQ_ABORT_EN
         aborted_q  <= aborted_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      ra_d       = ra_q;
      ca_d       = ca_q;
      rb_d       = rb_q;
      cb_d       = cb_q;
      row_d      = row_q;
      col_d      = col_q;
      sel_d      = sel_q;
      err_code_d = err_code_q;
`ifdef MMUL_SEQ_ABORT_EN
      aborted_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               ra_d  = cmd_ra_i;
               ca_d  = cmd_ca_i;
               rb_d  = cmd_rb_i;
               cb_d  = cmd_cb_i;
               row_d = '0;
               col_d = '0;
               sel_d = 1'b0;
               // Checks are prioritised: inner-dimension mismatch, then zero, then oversize.
               if (cmd_ca_i != cmd_rb_i) begin
                  state_d    = REJ;
                  err_code_d = 2'b01;
               end else if ((cmd_ra_i == '0) || (cmd_ca_i == '0) ||
                            (cmd_rb_i == '0) || (cmd_cb_i == '0)) begin
                  state_d    = REJ;
                  err_code_d = 2'b10;
               end else if ((cmd_ra_i > MAX_V) || (cmd_ca_i > MAX_V) ||
                            (cmd_rb_i > MAX_V) || (cmd_cb_i > MAX_V)) begin
                  state_d    = REJ;
                  err_code_d = 2'b11;
               end else begin
                  state_d = STREAM_A;
               end
            end
         end
         STREAM_A, STREAM_B: begin
            if (xfer) begin
               if (last_elem) begin
                  row_d = '0;
                  col_d = '0;
                  if (state_q == STREAM_A) begin
                     sel_d   = 1'b1;
                     state_d = STREAM_B;
                  end else begin
                     sel_d   = 1'b0;
                     state_d = FIN;
                  end
               end else if (col_end) begin
                  col_d = '0;
                  row_d = row_q + ONE_V;
               end else begin
                  col_d = col_q + ONE_V;
               end
            end
         end
         FIN: begin
            sel_d   = 1'b0;
            state_d = IDLE;
         end
         REJ: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef MMUL_SEQ_ABORT_EN
      // Abort overrides everything, including a simultaneous final transfer.
      if (streaming && abort_i) begin
         state_d   = IDLE;
         row_d     = '0;
         col_d     = '0;
         sel_d     = 1'b0;
         aborted_d = 1'b1;
      end
`endif
   end

   always_comb begin
      cmd_ready_o = 1'b0;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      out_last_o  = 1'b0;
      done_o      = 1'b0;
      err_o       = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
         end
         STREAM_A, STREAM_B: begin
            in_ready_o  = out_ready_i;
            out_valid_o = in_valid_i;
            out_last_o  = last_elem;
         end
         FIN: begin
            done_o = 1'b1;
         end
         REJ: begin
            err_o = 1'b1;
         end
         default: begin
            cmd_ready_o = 1'b0;
         end
      endcase
   end

   assign out_data_o = in_data_i;
   assign out_sel_o  = sel_q;
   assign out_row_o  = row_q;
   assign out_col_o  = col_q;
   assign err_code_o = err_code_q;
`ifdef MMUL_SEQ_ABORT_EN
   assign aborted_o  = aborted_q;
`endif

endmodule

// File: tb/tb_mmul_operand_sequencer.sv
// Self-checking bench for mmul_operand_sequencer: expected tags come from nested-loop enumeration of each matrix.
// The abort scenario is exercised only when MMUL_SEQ_ABORT_EN is defined.
module tb_mmul_operand_sequencer;

   localparam int DATA_W  = 16;
   localparam int DIM_W   = 4;
   localparam int MAX_DIM = 8;

   typedef struct packed {
      logic             sel;
      logic [DIM_W-1:0] row;
      logic [DIM_W-1:0] col;
      logic             last;
   } tag_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [DIM_W-1:0]  cmd_ra, cmd_ca, cmd_rb, cmd_cb;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_sel;
   logic [DIM_W-1:0]  out_row, out_col;
   logic              out_last;
   logic              done, err;
   logic [1:0]        err_code;
`ifdef MMUL_SEQ_ABORT_EN
   logic              abort;
   logic              aborted;
`endif

   int         nCompared   = 0;
   int         nMismatched = 0;
   logic [1:0] lastErrCode = 2'b00;

   always #5 clk = ~clk;

   mmul_operand_sequencer #(
      .DATA_W (DATA_W),
      .DIM_W  (DIM_W),
      .MAX_DIM(MAX_DIM)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(cmd_ready),
      .cmd_ra_i   (cmd_ra),
      .cmd_ca_i   (cmd_ca),
      .cmd_rb_i   (cmd_rb),
      .cmd_cb_i   (cmd_cb),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_data_i  (in_data),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .out_sel_o  (out_sel),
      .out_row_o  (out_row),
      .out_col_o  (out_col),
      .out_last_o (out_last),
      .done_o     (done),
      .err_o      (err),
      .err_code_o (err_code)
`ifdef MMUL_SEQ_ABORT_EN
      ,
      .abort_i    (abort),
      .aborted_o  (aborted)
`endif
   );

   // Command legality straight from the rules: mismatch, then zero, then oversize.
   function automatic logic [1:0] expect_code(input int ra, input int ca, input int rb, input int cb);
      if (ca != rb) return 2'b01;
      if (ra == 0 || ca == 0 || rb == 0 || cb == 0) return 2'b10;
      if (ra > MAX_DIM || ca > MAX_DIM || rb > MAX_DIM || cb > MAX_DIM) return 2'b11;
      return 2'b00;
   endfunction

   task automatic build_tags(input int ra, input int ca, input int rb, input int cb, output tag_t q[$]);
      int rows, cols;
      q = {};
      for (int m = 0; m < 2; m++) begin
         rows = (m == 0) ? ra : rb;
         cols = (m == 0) ? ca : cb;
         for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
               q.push_back('{sel: m[0], row: r[DIM_W-1:0], col: c[DIM_W-1:0],
                             last: (r == rows - 1) && (c == cols - 1)});
      end
   endtask

   task automatic idle_inputs();
      cmd_valid = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
`ifdef MMUL_SEQ_ABORT_EN
      abort     = 1'b0;
`endif
   endtask

   // Issues one command and, if legal, streams both matrices. mode 0: always ready, data 1..N;
   // mode 1: random valid/ready; mode 2: out_ready toggling 1,0,1,...
   task automatic do_command(input int ra, input int ca, input int rb, input int cb, input int mode);
      tag_t       expq[$];
      tag_t       t;
      logic [1:0] code;
      logic       iv, ordy;
      logic [DATA_W-1:0] d;
      int         k, dataIdx;
      cmd_ra    = ra[DIM_W-1:0];
      cmd_ca    = ca[DIM_W-1:0];
      cmd_rb    = rb[DIM_W-1:0];
      cmd_cb    = cb[DIM_W-1:0];
      cmd_valid = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      nCompared++;
      if (cmd_ready !== 1'b1 || err_code !== lastErrCode) begin
         nMismatched++;
         $display("[TB] FAIL cmd_accept: cmd_ready=%b err_code=%b, required cmd_ready=1 err_code=%b",
                  cmd_ready, err_code, lastErrCode);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_ra = DIM_W'($urandom);
      cmd_ca = DIM_W'($urandom);
      cmd_rb = DIM_W'($urandom);
      cmd_cb = DIM_W'($urandom);
      code = expect_code(ra, ca, rb, cb);
      if (code != 2'b00) begin
         @(negedge clk);
         nCompared++;
         if (err !== 1'b1 || err_code !== code || in_ready !== 1'b0 || cmd_ready !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reject_pulse: err=%b code=%b in_ready=%b cmd_ready=%b done=%b, required err=1 code=%b in_ready=0 cmd_ready=0 done=0",
                     err, err_code, in_ready, cmd_ready, done, code);
         end
         lastErrCode = code;
         @(posedge clk); #1;
         @(negedge clk);
         nCompared++;
         if (err !== 1'b0 || cmd_ready !== 1'b1 || err_code !== code) begin
            nMismatched++;
            $display("[TB] FAIL reject_after: err=%b cmd_ready=%b code=%b, required err=0 cmd_ready=1 code=%b",
                     err, cmd_ready, err_code, code);
         end
         @(posedge clk); #1;
         return;
      end
      build_tags(ra, ca, rb, cb, expq);
      k = 0;
      dataIdx = 0;
      while (expq.size() > 0 && k < 4000) begin
         case (mode)
            0: begin iv = 1'b1; ordy = 1'b1; d = DATA_W'(dataIdx + 1); end
            1: begin iv = ($urandom % 4) != 0; ordy = ($urandom % 4) != 0; d = DATA_W'($urandom); end
            default: begin iv = 1'b1; ordy = (k % 2) == 0; d = DATA_W'($urandom); end
         endcase
         in_valid  = iv;
         out_ready = ordy;
         in_data   = d;
         @(negedge clk);
         nCompared++;
         if (out_valid !== iv || in_ready !== ordy || cmd_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL stream_handshake: out_valid=%b in_ready=%b cmd_ready=%b done=%b err=%b, required %b %b 0 0 0",
                     out_valid, in_ready, cmd_ready, done, err, iv, ordy);
         end
         if (iv && ordy) begin
            t = expq.pop_front();
            nCompared++;
            if (out_data !== d || out_sel !== t.sel || out_row !== t.row || out_col !== t.col || out_last !== t.last) begin
               nMismatched++;
               $display("[TB] FAIL element_tag: data=%h sel=%b row=%0d col=%0d last=%b, required data=%h sel=%b row=%0d col=%0d last=%b",
                        out_data, out_sel, out_row, out_col, out_last, d, t.sel, t.row, t.col, t.last);
            end
            dataIdx++;
         end
         @(posedge clk); #1;
         k++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (expq.size() != 0) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL stream_timeout: %0d elements still pending, required 0", expq.size());
      end
      @(negedge clk);
      nCompared++;
      if (done !== 1'b1 || out_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL done_pulse: done=%b out_valid=%b cmd_ready=%b, required done=1 out_valid=0 cmd_ready=0",
                  done, out_valid, cmd_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      nCompared++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL done_after: done=%b cmd_ready=%b, required done=0 cmd_ready=1", done, cmd_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      lastErrCode = 2'b00;
      @(negedge clk);
      nCompared++;
      if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 ||
          err !== 1'b0 || err_code !== 2'b00 || out_row !== '0 || out_col !== '0 || out_sel !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_state: cmd_ready=%b in_ready=%b out_valid=%b done=%b err=%b code=%b row=%0d col=%0d sel=%b, required 1 0 0 0 0 00 0 0 0",
                  cmd_ready, in_ready, out_valid, done, err, err_code, out_row, out_col, out_sel);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_directed_stream();
      do_command(2, 3, 3, 2, 0);
      do_command(8, 1, 1, 8, 1);
   endtask

   task automatic test_reject();
      do_command(2, 3, 2, 2, 0);
      do_command(0, 2, 2, 1, 0);
      do_command(9, 1, 1, 1, 0);
      do_command(2, 0, 0, 3, 0);
      do_command(1, 9, 9, 1, 0);
   endtask

   task automatic test_1x1_toggle();
      do_command(1, 1, 1, 1, 2);
   endtask

   task automatic test_reset_midstream();
      tag_t expq[$];
      tag_t t;
      build_tags(2, 3, 3, 2, expq);
      cmd_ra = 4'd2; cmd_ca = 4'd3; cmd_rb = 4'd3; cmd_cb = 4'd2;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_data   = DATA_W'($urandom);
         @(negedge clk);
         t = expq.pop_front();
         nCompared++;
         if (out_valid !== 1'b1 || out_row !== t.row || out_col !== t.col || out_sel !== t.sel) begin
            nMismatched++;
            $display("[TB] FAIL midstream_elem: valid=%b row=%0d col=%0d sel=%b, required 1 %0d %0d %b",
                     out_valid, out_row, out_col, out_sel, t.row, t.col, t.sel);
         end
         @(posedge clk); #1;
      end
      rst_n    = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      lastErrCode = 2'b00;
      @(negedge clk);
      nCompared++;
      if (cmd_ready !== 1'b1 || out_row !== '0 || out_col !== '0 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL midstream_reset: cmd_ready=%b row=%0d col=%0d done=%b err=%b in_ready=%b, required 1 0 0 0 0 0",
                  cmd_ready, out_row, out_col, done, err, in_ready);
      end
      @(posedge clk); #1;
      do_command(1, 2, 2, 1, 1);
   endtask

   task automatic test_random();
      int ra, ca, rb, cb;
      for (int n = 0; n < 24; n++) begin
         ra = $urandom % 10;
         ca = $urandom % 10;
         cb = $urandom % 10;
         rb = (($urandom % 4) != 0) ? ca : int'($urandom % 10);
         if (($urandom % 3) != 0) begin
            ra = 1 + ($urandom % MAX_DIM);
            ca = 1 + ($urandom % MAX_DIM);
            rb = ca;
            cb = 1 + ($urandom % MAX_DIM);
         end
         do_command(ra, ca, rb, cb, 1);
      end
   endtask

`ifdef MMUL_SEQ_ABORT_EN
   task automatic test_abort();
      tag_t expq[$];
      tag_t t;
      build_tags(1, 2, 2, 2, expq);
      cmd_ra = 4'd1; cmd_ca = 4'd2; cmd_rb = 4'd2; cmd_cb = 4'd2;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_data   = DATA_W'(i + 100);
         abort     = (i == 3);
         @(negedge clk);
         t = expq.pop_front();
         nCompared++;
         if (out_valid !== 1'b1 || out_data !== DATA_W'(i + 100) || out_row !== t.row || out_col !== t.col || out_sel !== t.sel) begin
            nMismatched++;
            $display("[TB] FAIL abort_elem: valid=%b data=%h row=%0d col=%0d sel=%b, required 1 %h %0d %0d %b",
                     out_valid, out_data, out_row, out_col, out_sel, DATA_W'(i + 100), t.row, t.col, t.sel);
         end
         @(posedge clk); #1;
      end
      abort    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      nCompared++;
      if (aborted !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b1 || out_row !== '0 || out_col !== '0 || out_sel !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL abort_pulse: aborted=%b done=%b cmd_ready=%b row=%0d col=%0d sel=%b, required 1 0 1 0 0 0",
                  aborted, done, cmd_ready, out_row, out_col, out_sel);
      end
      do_command(2, 2, 2, 1, 0);
      @(negedge clk);
      nCompared++;
      if (aborted !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL abort_clear: aborted=%b, required 0", aborted);
      end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      test_reset();
      test_directed_stream();
      test_reject();
      test_1x1_toggle();
      test_reset_midstream();
      test_random();
`ifdef MMUL_SEQ_ABORT_EN
      test_abort();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
